// File: rtl/regfile_mp_if.sv
// regfile_mp_if
//   Groups the write, read, issue and scoreboard signals of regfile_mp.
//   master : the pipeline side (drives writes, read addresses and issues)
//   slave  : the register file itself
//   Signals:
//     we0/wa0/wd0   write port 0 (WB stage)
//     we1/wa1/wd1   write port 1 (late/load writeback), priority over port 0
//     ra            NR packed read addresses, port i at [i*AW +: AW]
//     rd            NR packed read data, port i at [i*DW +: DW]
//     rd_busy       per read port: source register still pending
//     iss_en        mark iss_addr pending
//     iss_addr      register to mark pending
//     busy_vec      pending bit of every register
interface regfile_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 3
);
    logic                 we0;
    logic [AW-1:0]        wa0;
    logic [DW-1:0]        wd0;
    logic                 we1;
    logic [AW-1:0]        wa1;
    logic [DW-1:0]        wd1;
    logic [NR*AW-1:0]     ra;
    logic [NR*DW-1:0]     rd;
    logic [NR-1:0]        rd_busy;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [(1<<AW)-1:0]   busy_vec;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra, iss_en, iss_addr,
        input  rd, rd_busy, busy_vec
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra, iss_en, iss_addr,
        output rd, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-port integer register file for the ID stage: NR combinational
//   read ports with same-cycle write bypass, two write ports (port 1 wins
//   on an address collision) and a per-register pending scoreboard.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; clears array and scoreboard
//     bus    regfile_mp_if slave modport (see the interface header)
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 3,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int   DEPTH = 1 << AW;
    localparam logic ZR    = (ZERO_REG != 0);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic eff0;
    logic eff1;
    logic iss_ok;

    // Writes to the hard-wired zero register are dropped entirely, so they
    // neither bypass nor clear a busy bit.
    assign eff0   = bus.we0 && !(ZR && (bus.wa0 == '0));
    assign eff1   = bus.we1 && !(ZR && (bus.wa1 == '0));
    assign iss_ok = bus.iss_en && !(ZR && (bus.iss_addr == '0));

    // Port 1 is applied last so it overwrites port 0 on the same address.
    always_comb begin
        mem_d = mem_q;
        if (eff0) mem_d[bus.wa0] = bus.wd0;
        if (eff1) mem_d[bus.wa1] = bus.wd1;
    end

    // Clears first, then the issue set: a younger producer issued in the
    // same cycle as the older one retires keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (eff0)   busy_d[bus.wa0]      = 1'b0;
        if (eff1)   busy_d[bus.wa1]      = 1'b0;
        if (iss_ok) busy_d[bus.iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit0;
        logic          hit1;
        logic          zr_hit;
        logic [DW-1:0] data;

        assign addr   = bus.ra[g*AW +: AW];
        assign hit0   = eff0 && (bus.wa0 == addr);
        assign hit1   = eff1 && (bus.wa1 == addr);
        assign zr_hit = ZR && (addr == '0);

        always_comb begin
            data = mem_q[addr];
            if (zr_hit)    data = '0;
            else if (hit1) data = bus.wd1;
            else if (hit0) data = bus.wd0;
        end

        assign bus.rd[g*DW +: DW] = data;
        // A value arriving through the bypass this cycle is already usable.
        assign bus.rd_busy[g]     = busy_q[addr] && !hit0 && !hit1 && !zr_hit;
    end

    assign bus.busy_vec = busy_q;

endmodule
